cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, SHALL set the width of the miss, memory and cache addresses.
REQ-002 Parameter BLOCK_WORDS, default 8, SHALL set the 16-bit words per cache block; power of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 miss_detected  input  1  SHALL be the cache miss indication.
REQ-006 miss_address  input  ADDR_WIDTH  SHALL be the missing byte address.
REQ-007 arbiter_select  input  1  SHALL be the grant for the shared memory port.
REQ-008 memory_data  input  16  SHALL be the memory return word.
REQ-009 memory_data_valid  input  1  SHALL qualify memory_data.
REQ-010 fill_req  output  1  SHALL request the memory port.
REQ-011 mem_read  output  1  SHALL mark a read issued on memory_address this cycle.
REQ-012 memory_address  output  ADDR_WIDTH  SHALL be the read address.
REQ-013 cache_address  output  ADDR_WIDTH  SHALL be the cache address for the current data write.
REQ-014 cache_data  output  16  SHALL be memory_data passed through combinationally.
REQ-015 write_data_array  output  1  SHALL be the data-array word write strobe.
REQ-016 write_tag_array  output  1  SHALL be the one-cycle metadata (tag/valid/LRU) write strobe.
REQ-017 fsm_busy  output  1  SHALL stall the pipeline while a fill is outstanding.

Function
REQ-018 The block SHALL have exactly three states: IDLE, REQ and FILL.
REQ-019 In IDLE, miss_detected=1 SHALL latch base = miss_address with bits [log2(2*BLOCK_WORDS)-1:0] cleared and SHALL move to REQ next cycle.
REQ-020 REQ SHALL assert fill_req and SHALL move to FILL on the first cycle arbiter_select=1.
REQ-021 In FILL, mem_read SHALL be 1 for exactly BLOCK_WORDS consecutive cycles, with memory_address = base + 2*issue_cnt, issue_cnt running 0..BLOCK_WORDS-1.
REQ-022 fill_req SHALL stay 1 throughout FILL.
REQ-023 In FILL, each memory_data_valid=1 cycle SHALL assert write_data_array with cache_address = base + 2*recv_cnt, then increment recv_cnt.
REQ-024 memory_data_valid SHALL be accepted in the same cycle as mem_read; the block SHALL NOT assume any fixed memory latency.
REQ-025 On the valid that makes recv_cnt reach BLOCK_WORDS, write_tag_array SHALL pulse in that same cycle, cache_address SHALL equal base, and the state SHALL be IDLE next cycle.
REQ-026 fsm_busy SHALL be 1 in REQ and FILL and 0 in IDLE (Moore output).
REQ-027 memory_data_valid SHALL be ignored in IDLE and REQ.
REQ-028 miss_detected SHALL be ignored in REQ and FILL.
REQ-029 A miss in the cycle after completion SHALL start a new fill (back-to-back fills).
REQ-030 Address arithmetic SHALL be ADDR_WIDTH bits wide and wrap modulo 2^ADDR_WIDTH.
REQ-031 In IDLE, memory_address and cache_address SHALL be 0.

Reset
REQ-032 rst=1 SHALL force IDLE, base=0, issue_cnt=0, recv_cnt=0 and every output strobe to 0 on the next edge.
REQ-033 A reset during FILL SHALL abort the fill with no write_tag_array; later returning valids SHALL be ignored.

Configuration
REQ-034 With CACHE_FILL_PERF_EN defined, the block SHALL add output fill_count[15:0], reset to 0, incremented on each write_tag_array pulse, saturating at 16'hFFFF.
REQ-035 Without CACHE_FILL_PERF_EN, the fill_count port and its logic SHALL be absent.

Structure
REQ-036 The shared package cache_pkg SHALL hold the fill_state_t enum (IDLE, REQ, FILL) and the BLOCK_WORDS and ADDR_WIDTH default constants.
REQ-037 The one sub-module SHALL be fill_counter, a parameterised up-counter with clear and enable, instantiated twice (issue and receive).

Verification
REQ-038 miss_address=16'h1234, grant 2 cycles later, valid 4 cycles after each read -> reads 16'h1230..16'h123E, 8 write_data_array, one write_tag_array, fsm_busy falls after the 8th valid.
REQ-039 arbiter_select held 0 for 10 cycles -> fill_req=1, mem_read=0, fsm_busy=1 throughout.
REQ-040 rst=1 on the 3rd valid -> IDLE next cycle, no write_tag_array, 5 late valids produce no writes.
REQ-041 miss_address=16'hFFF6 -> reads 16'hFFF0..16'hFFFE, no wrap past the block.
REQ-042 miss_detected held 1 through and after a fill -> second fill starts the cycle after write_tag_array; with CACHE_FILL_PERF_EN, fill_count=2.
REQ-043 memory_data_valid in the same cycle as each mem_read -> 8 writes, completion 8 cycles after entering FILL.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and default sizing for the cache block-fill controller.
package cache_pkg;

    // Controller states: wait for miss, wait for memory grant, stream block in
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } fill_state_t;

    localparam int DEFAULT_ADDR_WIDTH  = 16;
    localparam int DEFAULT_BLOCK_WORDS = 8;

    // Number of byte-offset bits inside one block of 16-bit words
    function automatic int block_offset_bits(input int block_words);
        return $clog2(2 * block_words);
    endfunction

endpackage

// File: rtl/fill_counter.sv
// Up-counter with synchronous clear and count enable, used for the read-issue
// and data-receive indices of a block fill.
module fill_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Count register; reset and clear both return to zero
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block-fill controller.
//
// On a miss the block-aligned base address is captured, the shared memory
// port is requested, and once granted BLOCK_WORDS reads are issued on
// consecutive cycles. Returning words are written into the data array in
// arrival order with no assumption about memory latency; the last word also
// pulses the metadata write and ends the fill.
//
// state | meaning
// IDLE  | no fill outstanding, waiting for miss_detected
// REQ   | fill_req raised, waiting for arbiter_select
// FILL  | issuing reads and accepting returned words
//
// Optional build macro CACHE_FILL_PERF_EN adds a saturating 16-bit count of
// completed fills on port fill_count.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH  = cache_pkg::DEFAULT_ADDR_WIDTH,
    parameter int BLOCK_WORDS = cache_pkg::DEFAULT_BLOCK_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    input  logic                  arbiter_select,
    input  logic [15:0]           memory_data,
    input  logic                  memory_data_valid,
    output logic                  fill_req,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [ADDR_WIDTH-1:0] cache_address,
    output logic [15:0]           cache_data,
    output logic                  write_data_array,
    output logic                  write_tag_array,
    output logic                  fsm_busy
`ifdef CACHE_FILL_PERF_EN
    ,
    output logic [15:0]           fill_count
`endif
);

    import cache_pkg::*;

    // Counters must be able to hold BLOCK_WORDS itself so "all issued" is visible
    localparam int CNT_W    = $clog2(BLOCK_WORDS) + 1;
    localparam int OFS_BITS = block_offset_bits(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK = ~ADDR_WIDTH'((1 << OFS_BITS) - 1);
    localparam logic [CNT_W-1:0] CNT_ALL  = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

    fill_state_t           state;
    fill_state_t           next_state;
    logic [ADDR_WIDTH-1:0] base;
    logic                  base_load;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      recv_cnt;
    logic                  counters_clear;
    logic                  issue_active;
    logic                  recv_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH-1:0] recv_addr;

    // Word offsets are doubled because addresses are byte addresses of 16-bit words
    assign issue_addr   = base + (ADDR_WIDTH'(issue_cnt) << 1);
    assign recv_addr    = base + (ADDR_WIDTH'(recv_cnt) << 1);
    assign issue_active = (issue_cnt < CNT_ALL);
    assign recv_last    = (recv_cnt == CNT_LAST);

    // Counters only run inside a fill; leaving FILL (normally or by reset) zeroes them
    assign counters_clear = (state != FILL);

    assign cache_data = memory_data;
    assign fsm_busy   = (state != IDLE);

    fill_counter #(.WIDTH(CNT_W)) u_issue_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (counters_clear),
        .enable (mem_read),
        .count  (issue_cnt)
    );

    fill_counter #(.WIDTH(CNT_W)) u_recv_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (counters_clear),
        .enable (write_data_array),
        .count  (recv_cnt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Block base address, captured with the in-block offset stripped
    always_ff @(posedge clk) begin
        if (rst) begin
            base <= '0;
        end else if (base_load) begin
            base <= miss_address & BASE_MASK;
        end
    end

    // Next-state and output decode
    always_comb begin
        next_state       = state;
        base_load        = 1'b0;
        fill_req         = 1'b0;
        mem_read         = 1'b0;
        memory_address   = '0;
        cache_address    = '0;
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        case (state)
            IDLE: begin
                if (miss_detected) begin
                    base_load  = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                fill_req = 1'b1;
                if (arbiter_select) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                fill_req       = 1'b1;
                mem_read       = issue_active;
                memory_address = issue_addr;
                cache_address  = recv_addr;
                if (memory_data_valid) begin
                    write_data_array = 1'b1;
                    if (recv_last) begin
                        // Final word: metadata write is addressed at the block base
                        write_tag_array = 1'b1;
                        cache_address   = base;
                        next_state      = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef CACHE_FILL_PERF_EN
    // Completed-fill counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_count <= '0;
        end else if (write_tag_array && (fill_count != 16'hFFFF)) begin
            fill_count <= fill_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed testbench for cache_fill_fsm (default ADDR_WIDTH=16, BLOCK_WORDS=8).
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        arbiter_select;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fill_req;
    logic        mem_read;
    logic [15:0] memory_address;
    logic [15:0] cache_address;
    logic [15:0] cache_data;
    logic        write_data_array;
    logic        write_tag_array;
    logic        fsm_busy;
`ifdef CACHE_FILL_PERF_EN
    logic [15:0] fill_count;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int n_wda;
    int n_wta;
    logic [15:0] exp_data;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .arbiter_select    (arbiter_select),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fill_req          (fill_req),
        .mem_read          (mem_read),
        .memory_address    (memory_address),
        .cache_address     (cache_address),
        .cache_data        (cache_data),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .fsm_busy          (fsm_busy)
`ifdef CACHE_FILL_PERF_EN
        ,
        .fill_count        (fill_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Step to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        miss_detected     = 1'b0;
        arbiter_select    = 1'b0;
        memory_data_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Enters FILL on the first tick; every read gets its data in the same cycle
    task automatic fill_fast(input logic [15:0] base);
        for (int k = 0; k < 8; k++) begin
            tick();
            arbiter_select    = 1'b0;
            exp_data          = 16'hC000 ^ base ^ 16'(k);
            memory_data       = exp_data;
            memory_data_valid = 1'b1;
            #1;
            chk("ff_mem_read", mem_read, 1);
            chk("ff_mem_addr", memory_address, base + 16'(2 * k));
            chk("ff_wda", write_data_array, 1);
            chk("ff_wta", write_tag_array, (k == 7));
            chk("ff_cache_addr", cache_address, (k == 7) ? base : base + 16'(2 * k));
            chk("ff_cache_data", cache_data, exp_data);
            chk("ff_busy", fsm_busy, 1);
        end
        tick();
        memory_data_valid = 1'b0;
        #1;
        chk("ff_done_busy", fsm_busy, 0);
        chk("ff_done_fill_req", fill_req, 0);
        chk("ff_done_mem_read", mem_read, 0);
    endtask

    initial begin
        miss_address = '0;
        memory_data  = '0;

        // Reset state
        rst               = 1'b1;
        miss_detected     = 1'b0;
        arbiter_select    = 1'b0;
        memory_data_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_busy", fsm_busy, 0);
        chk("rst_fill_req", fill_req, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_wda", write_data_array, 0);
        chk("rst_wta", write_tag_array, 0);
        chk("rst_mem_addr", memory_address, 16'h0000);
        chk("rst_cache_addr", cache_address, 16'h0000);
`ifdef CACHE_FILL_PERF_EN
        chk("rst_fill_count", fill_count, 0);
`endif
        rst = 1'b0;

        // Miss 0x1234, grant two cycles into REQ, data 4 cycles after each read
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'h1234;
        #1;
        chk("t1_idle_busy", fsm_busy, 0);
        chk("t1_idle_fill_req", fill_req, 0);
        tick();
        miss_detected = 1'b0;
        #1;
        chk("t1_req_fill_req", fill_req, 1);
        chk("t1_req_busy", fsm_busy, 1);
        chk("t1_req_mem_read", mem_read, 0);
        tick();
        #1;
        chk("t1_req2_fill_req", fill_req, 1);
        tick();
        arbiter_select = 1'b1;
        #1;
        chk("t1_req3_mem_read", mem_read, 0);
        n_wda = 0;
        n_wta = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            arbiter_select    = 1'b0;
            memory_data_valid = (k >= 4);
            exp_data          = 16'h5A00 + 16'(k);
            memory_data       = exp_data;
            #1;
            if (write_data_array) n_wda++;
            if (write_tag_array) n_wta++;
            chk("t1_mem_read", mem_read, (k < 8));
            if (k < 8) chk("t1_mem_addr", memory_address, 16'h1230 + 16'(2 * k));
            chk("t1_wda", write_data_array, (k >= 4));
            chk("t1_wta", write_tag_array, (k == 11));
            chk("t1_fill_req", fill_req, 1);
            chk("t1_busy", fsm_busy, 1);
            if (k >= 4) begin
                chk("t1_cache_addr", cache_address, (k == 11) ? 16'h1230 : 16'h1230 + 16'(2 * (k - 4)));
                chk("t1_cache_data", cache_data, exp_data);
            end
        end
        chk("t1_n_wda", n_wda, 8);
        chk("t1_n_wta", n_wta, 1);
        tick();
        memory_data_valid = 1'b0;
        #1;
        chk("t1_end_busy", fsm_busy, 0);
        chk("t1_end_mem_addr", memory_address, 16'h0000);
        chk("t1_end_cache_addr", cache_address, 16'h0000);

        // Grant withheld 10 cycles (valids ignored in REQ), then zero-latency fill
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'h0047;
        #1;
        for (int i = 0; i < 10; i++) begin
            tick();
            miss_detected     = 1'b0;
            arbiter_select    = 1'b0;
            memory_data_valid = 1'b1;
            #1;
            chk("t2_fill_req", fill_req, 1);
            chk("t2_mem_read", mem_read, 0);
            chk("t2_busy", fsm_busy, 1);
            chk("t2_wda", write_data_array, 0);
            chk("t2_wta", write_tag_array, 0);
        end
        tick();
        arbiter_select    = 1'b1;
        memory_data_valid = 1'b0;
        #1;
        chk("t2_grant_mem_read", mem_read, 0);
        fill_fast(16'h0040);

        // Reset on the third returned word aborts the fill
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'h2000;
        #1;
        tick();
        miss_detected  = 1'b0;
        arbiter_select = 1'b1;
        #1;
        chk("t3_req_busy", fsm_busy, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            arbiter_select    = 1'b0;
            memory_data_valid = (k >= 2);
            memory_data       = 16'h7700 + 16'(k);
            if (k == 4) rst = 1'b1;
            #1;
            if (k < 4) begin
                chk("t3_mem_read", mem_read, 1);
                chk("t3_wda", write_data_array, (k >= 2));
                chk("t3_wta", write_tag_array, 0);
            end
        end
        tick();
        rst               = 1'b0;
        memory_data_valid = 1'b0;
        #1;
        chk("t3_abort_busy", fsm_busy, 0);
        chk("t3_abort_fill_req", fill_req, 0);
        chk("t3_abort_mem_read", mem_read, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            memory_data_valid = 1'b1;
            #1;
            chk("t3_late_wda", write_data_array, 0);
            chk("t3_late_wta", write_tag_array, 0);
            chk("t3_late_busy", fsm_busy, 0);
        end

        // Block at the top of the address space
        tick();
        memory_data_valid = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'hFFF6;
        #1;
        tick();
        miss_detected  = 1'b0;
        arbiter_select = 1'b1;
        #1;
        chk("t4_req_fill_req", fill_req, 1);
        fill_fast(16'hFFF0);

        // Miss held high: second fill follows immediately; address change mid-fill ignored
        do_reset();
        tick();
        miss_detected = 1'b1;
        miss_address  = 16'h0100;
        #1;
        tick();
        arbiter_select = 1'b1;
        miss_address   = 16'h0208;
        #1;
        chk("t5_req_busy", fsm_busy, 1);
        fill_fast(16'h0100);
        tick();
        miss_detected  = 1'b0;
        arbiter_select = 1'b1;
        #1;
        chk("t5_second_busy", fsm_busy, 1);
        chk("t5_second_fill_req", fill_req, 1);
        chk("t5_second_mem_read", mem_read, 0);
        fill_fast(16'h0200);
`ifdef CACHE_FILL_PERF_EN
        chk("t5_fill_count", fill_count, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
